// File: rtl/led_pwm_driver_pkg.sv
// Shared constants, types and the gamma mapping for the LED PWM driver.
// The gamma helper is only called when LED_PWM_GAMMA_EN is defined.
package led_pwm_pkg;

  localparam int NUM_LEDS = 8;
  localparam int DUTY_W   = 8;
  localparam int CHAN_W   = 3;
  localparam int PHASE_W  = 8;

  typedef logic [DUTY_W-1:0]  duty_t;
  typedef logic [CHAN_W-1:0]  chan_t;
  typedef logic [PHASE_W-1:0] phase_t;

  // Square law: upper byte of the 16-bit product d*d.
  function automatic duty_t gamma_map(input duty_t d);
    logic [2*DUTY_W-1:0] prod;
    prod = {8'h00, d} * {8'h00, d};
    return prod[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage

// File: rtl/led_pwm_driver_if.sv
// Duty-write handshake bundle for led_pwm_driver: valid/ready plus channel and duty.
interface led_pwm_driver_if;
  import led_pwm_pkg::*;

  logic  in_valid;
  logic  in_ready;
  chan_t in_chan;
  duty_t in_duty;

  modport master (output in_valid, output in_chan, output in_duty, input in_ready);
  modport slave  (input in_valid, input in_chan, input in_duty, output in_ready);

endinterface

// File: rtl/led_pwm_driver_timebase.sv
// PWM timebase: prescaler producing a step every PRESCALE_DIV cycles and an
// 8-bit phase counter; boundary flags the step taken while phase is 255.
module pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 4
) (
  input  logic   clk,
  input  logic   rst,
  output logic   step,
  output phase_t phase,
  output logic   boundary
);

  localparam logic [15:0] TERM = 16'(PRESCALE_DIV - 1);

  logic [15:0] presc_r;
  phase_t      phase_r;

  assign step     = (presc_r == TERM);
  assign phase    = phase_r;
  assign boundary = step & (phase_r == 8'hFF);

  // Prescaler and phase counter; phase wraps 255 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= 16'h0000;
      phase_r <= 8'h00;
    end else begin
      if (step) begin
        presc_r <= 16'h0000;
        phase_r <= phase_r + 8'h01;
      end else begin
        presc_r <= presc_r + 16'h0001;
      end
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Eight-channel LED PWM driver: shadow duty writes, period-synchronous load into
// active duties, registered compare outputs. Optional macro: LED_PWM_GAMMA_EN.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  led_pwm_driver_if.slave     bus,
  output logic [NUM_LEDS-1:0] led,
  output logic                period_start
);

  logic                step_s;
  logic                boundary_s;
  logic                write_s;
  phase_t              phase_s;
  duty_t               shadow_r [NUM_LEDS];
  duty_t               active_r [NUM_LEDS];
  duty_t               load_s   [NUM_LEDS];
  logic [NUM_LEDS-1:0] cmp_s;
  logic [NUM_LEDS-1:0] led_r;
  logic                step_d_r;
  logic                period_start_r;

  pwm_timebase #(.PRESCALE_DIV(PRESCALE_DIV)) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .step     (step_s),
    .phase    (phase_s),
    .boundary (boundary_s)
  );

  // Writes are refused on the boundary so the shadow bank is stable while it loads.
  assign bus.in_ready = ~rst & ~boundary_s;
  assign write_s      = bus.in_valid & bus.in_ready;
  assign led          = led_r;
  assign period_start = period_start_r;

  // Value each active duty register takes at the period boundary.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef LED_PWM_GAMMA_EN
      load_s[i] = gamma_map(shadow_r[i]);
`else
      load_s[i] = shadow_r[i];
`endif
    end
  end

  // Per-channel comparison of the phase against the active duty.
  always_comb begin
    cmp_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      cmp_s[i] = (phase_s < active_r[i]);
    end
  end

  // Shadow bank: last accepted write per channel wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) shadow_r[i] <= '0;
    end else if (write_s) begin
      shadow_r[bus.in_chan] <= bus.in_duty;
    end
  end

  // Active bank: all channels reload together on the boundary step.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) active_r[i] <= '0;
    end else if (boundary_s) begin
      for (int i = 0; i < NUM_LEDS; i++) active_r[i] <= load_s[i];
    end
  end

  // Output registers; the compare can only change the cycle after a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_d_r       <= 1'b0;
      period_start_r <= 1'b0;
      led_r          <= '0;
    end else begin
      step_d_r       <= step_s;
      period_start_r <= boundary_s;
      if (step_d_r) led_r <= cmp_s;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench: two instances (PRESCALE_DIV 1 and 4) share one random and
// directed stimulus stream; a cycle-index reference model checks every cycle.
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v   = 1'b0;
  logic [2:0] c   = 3'd0;
  logic [7:0] d   = 8'd0;

  logic [7:0] led_a   [2];
  logic       ps_a    [2];
  logic       ready_a [2];

  int n_vec = 0;
  int n_err = 0;

`ifdef LED_PWM_GAMMA_EN
  localparam int E64 = 16, E128 = 64, E200 = 156, E90 = 31, E1 = 0;
`else
  localparam int E64 = 64, E128 = 128, E200 = 200, E90 = 90, E1 = 1;
`endif

  led_pwm_driver_if if0 ();
  led_pwm_driver_if if1 ();

  assign if0.in_valid = v;
  assign if0.in_chan  = c;
  assign if0.in_duty  = d;
  assign if1.in_valid = v;
  assign if1.in_chan  = c;
  assign if1.in_duty  = d;
  assign ready_a[0]   = if0.in_ready;
  assign ready_a[1]   = if1.in_ready;

  led_pwm_driver #(.PRESCALE_DIV(1)) dut (
    .clk(clk), .rst(rst), .bus(if0), .led(led_a[0]), .period_start(ps_a[0])
  );
  led_pwm_driver #(.PRESCALE_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if1), .led(led_a[1]), .period_start(ps_a[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: timing derived from the cycle index since reset release.
  int         divs [2] = '{1, 4};
  int         k    [2] = '{0, 0};
  int         m_sh [2][8];
  int         m_act[2][8];
  logic [7:0] m_led[2] = '{8'h00, 8'h00};
  logic       m_ps [2] = '{1'b0, 1'b0};

  function automatic int map_duty(input int s);
`ifdef LED_PWM_GAMMA_EN
    return (s * s) / 256;
`else
    return s;
`endif
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int   per;
      int   ph;
      bit   bnd;
      logic [7:0] nl;
      per = 256 * divs[u];
      ph  = (k[u] / divs[u]) % 256;
      bnd = (k[u] % per) == per - 1;
      check($sformatf("model_led%0d", u), led_a[u], m_led[u]);
      check($sformatf("model_ps%0d", u), ps_a[u], m_ps[u]);
      check($sformatf("model_ready%0d", u), ready_a[u], (rst || bnd) ? 0 : 1);
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_sh[u][i]  = 0;
          m_act[u][i] = 0;
        end
        m_led[u] = 8'h00;
        m_ps[u]  = 1'b0;
        k[u]     = 0;
      end else begin
        for (int i = 0; i < 8; i++) nl[i] = (ph < m_act[u][i]);
        m_led[u] = nl;
        m_ps[u]  = bnd;
        if (bnd) begin
          for (int i = 0; i < 8; i++) m_act[u][i] = map_duty(m_sh[u][i]);
        end else if (v) begin
          m_sh[u][c] = int'(d);
        end
        k[u]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps(input int u, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ps_a[u]) seen = 1'b1;
    end
    if (!seen) check("ps_timeout", 0, 1);
  endtask

  // Holds the write until both instances have taken it.
  task automatic write(input int ch, input int du);
    bit a0 = 1'b0;
    bit a1 = 1'b0;
    logic [31:0] chv = ch;
    logic [31:0] duv = du;
    v = 1'b1;
    c = chv[2:0];
    d = duv[7:0];
    for (int i = 0; i < 4 && !(a0 && a1); i++) begin
      @(negedge clk);
      if (ready_a[0]) a0 = 1'b1;
      if (ready_a[1]) a1 = 1'b1;
      tick();
    end
    v = 1'b0;
    if (!(a0 && a1)) check("write_timeout", 0, 1);
  endtask

  initial begin
    int n0, n7, nz, span, hi;
    repeat (3) tick();
    @(negedge clk);
    check("rst_led0", led_a[0], 0);
    check("rst_ps0", ps_a[0], 0);
    check("rst_ready1", ready_a[1], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst0", ready_a[0], 1);
    check("ready_after_rst1", ready_a[1], 1);

    // Chan 0 duty 64 and chan 7 duty 128, visible from the next period.
    tick();
    write(0, 64);
    write(7, 128);
    wait_ps(0, 600);
    check("led0_at_ps", led_a[0][0], 0);
    n0 = 0;
    n7 = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (j == 0) check("led0_ps_plus1", led_a[0][0], (E64 > 0) ? 1 : 0);
      if (led_a[0][0]) n0++;
      if (led_a[0][7]) n7++;
    end
    check("ch0_high_count", n0, E64);
    check("ch7_high_count", n7, E128);

    // Write held across the boundary cycle stalls one cycle then lands.
    wait_ps(0, 600);
    repeat (255) tick();
    v = 1'b1; c = 3'd3; d = 8'd200;
    @(negedge clk);
    check("ready_on_boundary", ready_a[0], 0);
    tick();
    @(negedge clk);
    check("ready_after_boundary", ready_a[0], 1);
    tick();
    v = 1'b0;
    wait_ps(0, 600);
    n0 = 0;
    repeat (256) begin @(negedge clk); if (led_a[0][3]) n0++; end
    check("ch3_stalled_count", n0, E200);

    // Two writes to chan 5 in one period: only the last counts.
    tick();
    write(5, 10);
    write(5, 90);
    wait_ps(0, 600);
    n0 = 0;
    repeat (256) begin @(negedge clk); if (led_a[0][5]) n0++; end
    check("ch5_last_write", n0, E90);

    // All duties 255, then reset at phase 100.
    tick();
    for (int ch = 0; ch < 8; ch++) write(ch, 255);
    wait_ps(0, 600);
    repeat (100) tick();
    rst = 1'b1;
    @(negedge clk);
    check("ready_in_rst", ready_a[0], 0);
    tick();
    @(negedge clk);
    check("led_in_rst", led_a[0], 0);
    check("ps_in_rst", ps_a[0], 0);
    tick();
    rst = 1'b0;
    nz = 0;
    repeat (300) begin @(negedge clk); if (led_a[0] != 8'h00 || led_a[1] != 8'h00) nz++; end
    check("led_dark_after_rst", nz, 0);

    // Slow instance: period spacing and duty 1.
    tick();
    write(1, 1);
    wait_ps(1, 2100);
    span = 0;
    hi = 0;
    for (int j = 0; j < 1100; j++) begin
      @(negedge clk);
      span++;
      if (led_a[1][1]) hi++;
      if (ps_a[1]) break;
    end
    check("div4_period", span, 1024);
    check("div4_duty1_high", hi, 4 * E1);

    // Random writes, including the duty extremes.
    for (int j = 0; j < 3000; j++) begin
      tick();
      v = ($urandom_range(0, 3) == 0);
      c = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       d = 8'd0;
        1:       d = 8'd255;
        default: d = 8'($urandom_range(0, 255));
      endcase
    end
    tick();
    v = 1'b0;
    repeat (1100) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter PRESCALE_DIV, default 4, clk cycles per PWM phase step; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  duty-write request.
REQ-005 in_ready  output  1  block can accept a duty write this cycle.
REQ-006 in_chan  input  3  target LED channel, 0..7.
REQ-007 in_duty  input  8  requested brightness, 0..255.
REQ-008 led  output  8  registered PWM outputs, one per channel.
REQ-009 period_start  output  1  one-cycle pulse marking the first cycle of a new PWM period.

Function
REQ-010 The prescaler SHALL count 0..PRESCALE_DIV-1 and wrap, asserting an internal step on the terminal count; PRESCALE_DIV=1 SHALL step every cycle.
REQ-011 The 8-bit phase counter SHALL increment on each step and wrap 255->0; one period = 256 steps.
REQ-012 A write transfer SHALL occur when in_valid && in_ready, storing in_duty into shadow[in_chan].
REQ-013 Multiple transfers to one channel within a period SHALL leave only the last value in shadow.
REQ-014 The boundary cycle is the step cycle with phase==255; on it, all 8 active duty registers SHALL load from shadow simultaneously.
REQ-015 in_ready SHALL be 0 on the boundary cycle and 1 on all other non-reset cycles; a stalled write SHALL complete on the next cycle without loss.
REQ-016 led[i] SHALL be registered as (phase < active[i]), with one-cycle latency from phase/active change to led.
REQ-017 Duty 0 SHALL hold led[i] low for the entire period; duty 255 SHALL give 255 high steps of 256.
REQ-018 period_start SHALL pulse high for exactly one cycle, on the cycle after the boundary cycle (the first cycle with phase==0).
REQ-019 A write accepted at cycle t SHALL affect led only from the period following the next boundary cycle after t; writes never alter the current period.

Reset
REQ-020 While rst is high: prescaler=0, phase=0, all shadow=0, all active=0, led=8'h00, period_start=0, in_ready=0.
REQ-021 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-022 rst asserted mid-period SHALL abort the period; the next period SHALL start from phase 0 with all duties 0; no write SHALL be accepted while rst is high.

Configuration
REQ-023 Macro LED_PWM_GAMMA_EN defined: active[i] SHALL load (shadow[i]*shadow[i])>>8 (16-bit product, upper byte), e.g. 128->64, 255->254, 15->0.
REQ-024 Macro LED_PWM_GAMMA_EN undefined: active[i] SHALL load shadow[i] unchanged, and no multiplier logic SHALL be present.

Structure
REQ-025 Shared package led_pwm_pkg SHALL hold NUM_LEDS=8, DUTY_W=8, CHAN_W=3, and the gamma-mapping function.
REQ-026 Prescaler plus phase counter SHALL be a sub-module pwm_timebase with outputs step, phase[7:0], boundary.
REQ-027 led_pwm_driver SHALL contain the shadow/active register banks, handshake logic and compare/output registers.

Verification (PRESCALE_DIV=1 unless stated)
REQ-028 Write chan 0 duty 64, no gamma -> from the next period, led[0] high for exactly 64 consecutive cycles starting at the period_start cycle +1, repeating every 256 cycles.
REQ-029 Hold in_valid on the boundary cycle with chan 3 duty 200 -> in_ready=0 that cycle, transfer completes next cycle, and led[3] shows 200 high cycles one period later.
REQ-030 Writes to chan 5 of duty 10 then 90 in one period -> next period led[5] high 90 cycles, never 10.
REQ-031 Assert rst at phase 100 with all duties 255 -> led=0 and period_start=0 during reset; after release led stays 0 until new writes plus a boundary.
REQ-032 LED_PWM_GAMMA_EN defined, chan 7 duty 128 -> 64 high cycles per period; duty 0 -> 0; duty 255 -> 254.
REQ-033 PRESCALE_DIV=4 -> period_start spacing 1024 cycles; duty 1 -> led high for 4 cycles per period.
